binary_to_decimal: RTL and testbench



---
 rtl/decimal_pkg.sv | 16 +
 rtl/dec_fifo2.sv | 49 ++++
 rtl/binary_to_decimal.sv | 66 ++++++
 tb/tb_binary_to_decimal.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/decimal_pkg.sv
// Constants and the code-to-one-hot helper shared by the decimal encoder and decoder.
package decimal_pkg;

  localparam int BIN_W   = 4;
  localparam int DEC_W   = 10;
  localparam int DEC_MAX = 9;

  // Codes above DEC_MAX have no decimal line, so they map to an all-zero word.
  function automatic logic [DEC_W-1:0] bin_to_onehot(input logic [BIN_W-1:0] bin);
    logic [DEC_W-1:0] onehot;
    onehot = '0;
    if (int'(bin) <= DEC_MAX) onehot[bin] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/dec_fifo2.sv
// Two-entry synchronous FIFO; an empty FIFO presents an all-zero head word.
module dec_fifo2 #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      // A simultaneous push and pop leaves occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/binary_to_decimal.sv
// Registered 4-bit binary to one-hot decimal decoder with a 2-entry output
// buffer and a saturating count of out-of-range codes.
module binary_to_decimal #(
  parameter int DEC_W     = 10,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_binary,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DEC_W-1:0]     out_decimal,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clr_err
);

  import decimal_pkg::*;

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic             push;
  logic             pop;
  logic             code_err;
  logic             full;
  logic             empty;
  logic [DEC_W:0]   wdata;
  logic [DEC_W:0]   rdata;

  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign code_err = (int'(in_binary) > DEC_MAX);
  assign wdata    = {bin_to_onehot(in_binary), code_err};

  // Handshake flags come straight from registered occupancy, never from inputs.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign {out_decimal, out_err} = rdata;

  dec_fifo2 #(
    .W (DEC_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  // Clear takes priority over a coinciding error acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= '0;
    end else if (push && code_err && (err_count != ERR_MAX)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_binary_to_decimal.sv
// Scoreboard bench for binary_to_decimal: accepted codes are modelled into a
// queue and a monitor compares every presented head entry against it.
module tb_binary_to_decimal;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_binary;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_decimal;
  logic       out_err;
  logic [1:0] err_count;
  logic       clr_err;

  int checks   = 0;
  int failures = 0;

  logic [10:0] exp_q[$];
  int          model_err = 0;

  always #5 clk = ~clk;

  binary_to_decimal #(
    .DEC_W     (10),
    .ERR_CNT_W (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_binary   (in_binary),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_decimal (out_decimal),
    .out_err     (out_err),
    .err_count   (err_count),
    .clr_err     (clr_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Expected {decimal, err} word: the code's power of two, or an error flag.
  function automatic logic [10:0] refDecode(input int code);
    if (code <= 9) return {10'(2 ** code), 1'b0};
    return {10'd0, 1'b1};
  endfunction

  task automatic applyStimulus(input logic v, input logic [3:0] code, input logic rdy, input logic clr);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_binary = code;
    out_ready = rdy;
    clr_err   = clr;
  endtask

  task automatic sendCode(input logic [3:0] code, input logic rdy);
    bit taken = 0;
    applyStimulus(1'b1, code, rdy, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        taken = 1;
        break;
      end
    end
    if (!taken) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout actual=in_ready_low required=accept code=%0d", code);
    end
  endtask

  // Acceptance sampler: decides at the falling edge what the next rising edge takes.
  initial begin
    bit       acc;
    bit       clr;
    int       code;
    forever begin
      @(negedge clk);
      acc  = rst_n && in_valid && in_ready;
      clr  = rst_n && clr_err;
      code = int'(in_binary);
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (acc) exp_q.push_back(refDecode(code));
        if (clr) model_err = 0;
        else if (acc && code >= 10 && model_err < 3) model_err++;
      end
    end
  end

  // Monitor: compares presented outputs with the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checkOutput("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
        checkOutput("err_count", 32'(err_count), 32'(model_err));
        checkOutput("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (out_valid && exp_q.size() != 0) begin
          checkOutput("out_word", 32'({out_decimal, out_err}), 32'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_binary = 4'd0;
    out_ready = 1'b0;
    clr_err   = 1'b0;

    // Reset with random inputs wiggling
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_binary = 4'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 1));
      clr_err   = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_decimal", 32'(out_decimal), 32'd0);
      checkOutput("rst_out_err", 32'(out_err), 32'd0);
      checkOutput("rst_err_count", 32'(err_count), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    clr_err   = 1'b0;
    out_ready = 1'b1;

    $display("[TB] sweep 0..9");
    for (int n = 0; n < 10; n++) applyStimulus(1'b1, 4'(n), 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);

    $display("[TB] error code then valid code");
    applyStimulus(1'b1, 4'd12, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'd3, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("err_after_12", 32'(err_count), 32'd1);

    $display("[TB] backpressure");
    sendCode(4'd5, 1'b0);
    sendCode(4'd7, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'd9, 1'b0, 1'b0);
    sendCode(4'd9, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);

    $display("[TB] saturation and clear");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'd15, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("err_saturated", 32'(err_count), 32'd3);
    applyStimulus(1'b1, 4'd11, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("err_clear_wins", 32'(err_count), 32'd0);

    $display("[TB] reset mid-operation");
    sendCode(4'd1, 1'b0);
    sendCode(4'd2, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_out_decimal", 32'(out_decimal), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    model_err = 0;
    applyStimulus(1'b1, 4'd4, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
